fwrisc_trap_seq: RTL and testbench
==================================

Name: fwrisc_trap_seq

Overview:
- Trap/return sequencer that owns the register-file write port and RB read port while a trap is entered or an MRET executes.
- On exception or enabled interrupt: writes MEPC, then MCAUSE, through the regfile rd port; pulses `trap`; redirects fetch to mtvec.
- On MRET: reads MEPC through the rb port, pulses `tret`, redirects fetch to the saved PC.
- Sits between core writeback and fwrisc_regfile; stalls the core while active.

Parameters:
- MEPC_ADDR, 6'h2A, regfile 6-bit address of MEPC; must equal CSR_MEPC in the CSR address map.
- MCAUSE_ADDR, 6'h2B, regfile 6-bit address of MCAUSE; must equal CSR_MCAUSE.
- IRQ_CAUSE, 4'd11, cause code for the external interrupt.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- instr_boundary  in  1  core is between instructions; interrupts are sampled only when 1.
- exc_req  in  1  synchronous exception request, single-cycle pulse.
- exc_cause  in  4  exception cause code, valid with exc_req.
- exc_pc  in  32  PC to save, valid with exc_req or with an interrupt take.
- mret_req  in  1  MRET execute request, single-cycle pulse.
- irq  in  1  external interrupt level.
- meie  in  1  from regfile.
- mie  in  1  from regfile.
- mtvec  in  32  from regfile.
- core_rd_waddr  in  6  core writeback address.
- core_rd_wdata  in  32  core writeback data.
- core_rd_wen  in  1  core writeback enable.
- rd_waddr  out  6  to regfile.
- rd_wdata  out  32  to regfile.
- rd_wen  out  1  to regfile.
- rb_sel  out  1  1 = sequencer owns the regfile rb read port.
- rb_raddr  out  6  rb address while rb_sel=1.
- rb_rdata  in  32  regfile rb data; one-cycle read latency.
- trap  out  1  one-cycle pulse to regfile.
- tret  out  1  one-cycle pulse to regfile.
- pc_redirect  out  1  one-cycle pulse; the core loads pc_target.
- pc_target  out  32  redirect address.
- core_stall  out  1  sequencer busy.

Behaviour:
- States: IDLE, WR_MEPC, WR_MCAUSE, REDIRECT, MRET_RD, MRET_REDIR. State and latched pc/cause are registers; outputs are decoded from them.
- Reset (reset=0 at a clock edge):
  - state goes to IDLE; latched pc, cause and int-flag go to 0.
  - While reset=0, all outputs are 0, including rd_wen. The core pass-through is suppressed.
  - A reset mid-sequence abandons it: no further writes, no pulses.
- Take condition in IDLE, with priority exc_req > interrupt > mret_req:
  - Interrupt take = irq & meie & mie & instr_boundary.
  - Lower-priority requests in the same cycle are dropped; the core reissues.
- Trap accept in IDLE:
  - Latch exc_pc.
  - Latch cause = {int, 27'b0, code}; int=1 with code=IRQ_CAUSE for an interrupt, int=0 with code=exc_cause for an exception.
  - Next state WR_MEPC.
- WR_MEPC: rd_wen=1, rd_waddr=MEPC_ADDR, rd_wdata=latched pc, trap=1. Next WR_MCAUSE.
- WR_MCAUSE: rd_wen=1, rd_waddr=MCAUSE_ADDR, rd_wdata=latched cause. Next REDIRECT.
- REDIRECT: pc_redirect=1, pc_target per vector rule. Next IDLE.
- Trap latency: request at cycle N gives MEPC write at N+1, MCAUSE write at N+2, redirect at N+3, IDLE at N+4.
- MRET accept in IDLE: next MRET_RD.
- MRET_RD: rb_sel=1, rb_raddr=MEPC_ADDR. Next MRET_REDIR.
- MRET_REDIR:
  - rb_sel=1, rb_raddr=MEPC_ADDR (held).
  - pc_redirect=1, pc_target={rb_rdata[31:2],2'b00}, tret=1.
  - Next IDLE.
- core_stall = (state != IDLE).
- Write-port mux:
  - In IDLE, rd_* = core_rd_* (combinational pass-through).
  - In any other state, the sequencer drives rd_*; core_rd_wen is ignored and dropped. A simulation-only $display warning is issued if core_rd_wen=1 while not IDLE.
- When the sequencer does not drive rb or rd, rb_sel=0 and rb_raddr=0.
- Requests arriving while not IDLE are ignored; the core is stalled and must not issue them.

Optional Feature:
- Macro: FWRISC_TRAP_VECTORED_EN.
- Defined: if mtvec[1:0]==2'b01 and the latched int=1, pc_target = {mtvec[31:2],2'b00} + (cause_code << 2), 32-bit wrap. Otherwise pc_target = {mtvec[31:2],2'b00}.
- Undefined: pc_target is always {mtvec[31:2],2'b00}; mtvec[1:0] is ignored.

Test Plan:
- Exception: exc_req=1, exc_cause=4'd2, exc_pc=32'h0000_0100, mtvec=32'h0000_0200 at cycle N -> N+1 write MEPC=32'h100 with trap=1; N+2 write MCAUSE=32'h0000_0002; N+3 pc_redirect with pc_target=32'h200; core_stall=1 for N+1..N+3.
- Interrupt: irq=meie=mie=instr_boundary=1, exc_pc=32'h40 -> MCAUSE write 32'h8000_000B. Same stimulus with mie=0 -> no sequence starts.
- Priority: exc_req and irq together with mret_req -> exception cause written, no tret pulse.
- MRET: mret_req with MEPC holding 32'h0000_0123 -> rb_sel=1 and rb_raddr=MEPC_ADDR for 2 cycles; redirect to 32'h0000_0120 with tret=1.
- Reset mid-op: reset=0 in the WR_MCAUSE cycle -> no MCAUSE write and no redirect; next cycle IDLE with core pass-through restored.
- FWRISC_TRAP_VECTORED_EN: mtvec=32'h0000_1001 with interrupt -> pc_target=32'h0000_102C. Exception with the same mtvec -> pc_target=32'h0000_1000.

Source files
------------

// File: rtl/fwrisc_trap_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fwrisc_trap_seq: owns regfile rd/rb ports during trap entry and MRET.       |
// | Option: FWRISC_TRAP_VECTORED_EN (vectored interrupt targets). Rev 1.0       |
// +----------------------------------------------------------------------------+
module fwrisc_trap_seq #(
  parameter logic [5:0] MEPC_ADDR   = 6'h2A,
  parameter logic [5:0] MCAUSE_ADDR = 6'h2B,
  parameter logic [3:0] IRQ_CAUSE   = 4'd11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_boundary,
  input  logic        exc_req,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        mret_req,
  input  logic        irq,
  input  logic        meie,
  input  logic        mie,
  input  logic [31:0] mtvec,
  input  logic [5:0]  core_rd_waddr,
  input  logic [31:0] core_rd_wdata,
  input  logic        core_rd_wen,
  output logic [5:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  output logic        rb_sel,
  output logic [5:0]  rb_raddr,
  input  logic [31:0] rb_rdata,
  output logic        trap,
  output logic        tret,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        core_stall
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_MEPC    = 3'd1,
    WR_MCAUSE  = 3'd2,
    REDIRECT   = 3'd3,
    MRET_RD    = 3'd4,
    MRET_REDIR = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  code_q, code_d;
  logic        int_q, int_d;

  logic        irq_take;
  logic [31:0] trap_base;
  logic [31:0] trap_target;
  logic        unused_bits;

  assign irq_take  = irq & meie & mie & instr_boundary;
  assign trap_base = {mtvec[31:2], 2'b00};

`ifdef FWRISC_TRAP_VECTORED_EN
  // Only interrupts are vectored; exceptions always land on the base.
  assign trap_target = (mtvec[1:0] == 2'b01 && int_q) ?
                       trap_base + {26'b0, code_q, 2'b00} : trap_base;
  assign unused_bits = ^rb_rdata[1:0];
`else
  assign trap_target = trap_base;
  assign unused_bits = ^{mtvec[1:0], rb_rdata[1:0]};
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= 32'h0;
      code_q  <= 4'h0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      code_q  <= code_d;
      int_q   <= int_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    code_d      = code_q;
    int_d       = int_q;
    rd_waddr    = 6'h0;
    rd_wdata    = 32'h0;
    rd_wen      = 1'b0;
    rb_sel      = 1'b0;
    rb_raddr    = 6'h0;
    trap        = 1'b0;
    tret        = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 32'h0;
    core_stall  = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        rd_waddr = core_rd_waddr;
        rd_wdata = core_rd_wdata;
        rd_wen   = core_rd_wen;
        if (exc_req) begin
          pc_d    = exc_pc;
          code_d  = exc_cause;
          int_d   = 1'b0;
          state_d = WR_MEPC;
        end else if (irq_take) begin
          pc_d    = exc_pc;
          code_d  = IRQ_CAUSE;
          int_d   = 1'b1;
          state_d = WR_MEPC;
        end else if (mret_req) begin
          state_d = MRET_RD;
        end
      end
      WR_MEPC: begin
        rd_wen   = 1'b1;
        rd_waddr = MEPC_ADDR;
        rd_wdata = pc_q;
        trap     = 1'b1;
        state_d  = WR_MCAUSE;
      end
      WR_MCAUSE: begin
        rd_wen   = 1'b1;
        rd_waddr = MCAUSE_ADDR;
        rd_wdata = {int_q, 27'b0, code_q};
        state_d  = REDIRECT;
      end
      REDIRECT: begin
        pc_redirect = 1'b1;
        pc_target   = trap_target;
        state_d     = IDLE;
      end
      MRET_RD: begin
        rb_sel   = 1'b1;
        rb_raddr = MEPC_ADDR;
        state_d  = MRET_REDIR;
      end
      MRET_REDIR: begin
        rb_sel      = 1'b1;
        rb_raddr    = MEPC_ADDR;
        pc_redirect = 1'b1;
        pc_target   = {rb_rdata[31:2], 2'b00};
        tret        = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences every output, including the core pass-through.
    if (!reset) begin
      rd_waddr    = 6'h0;
      rd_wdata    = 32'h0;
      rd_wen      = 1'b0;
      rb_sel      = 1'b0;
      rb_raddr    = 6'h0;
      trap        = 1'b0;
      tret        = 1'b0;
      pc_redirect = 1'b0;
      pc_target   = 32'h0;
      core_stall  = 1'b0;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset && state_q != IDLE && core_rd_wen)
      $display("fwrisc_trap_seq: warning: core_rd_wen dropped while sequencer busy");
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_trap_seq.sv
`default_nettype none
// Directed bench for fwrisc_trap_seq: per-cycle expected outputs are queued
// as stimulus is driven and compared mid-cycle against the DUT.
module tb_fwrisc_trap_seq;

  localparam logic [5:0] MEPC_A   = 6'h2A;
  localparam logic [5:0] MCAUSE_A = 6'h2B;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_boundary, exc_req, mret_req, irq, meie, mie, core_rd_wen;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, mtvec, core_rd_wdata, rb_rdata;
  logic [5:0]  core_rd_waddr;
  logic [5:0]  rd_waddr, rb_raddr;
  logic [31:0] rd_wdata, pc_target;
  logic        rd_wen, rb_sel, trap, tret, pc_redirect, core_stall;

  typedef struct packed {
    logic        rd_wen;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        rb_sel;
    logic [5:0]  rb_raddr;
    logic        trap;
    logic        tret;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        core_stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_no   = 0;
  logic [31:0] mem [0:63];

  always #5 clock = ~clock;

  fwrisc_trap_seq dut (
    .clock(clock), .reset(reset), .instr_boundary(instr_boundary),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_req(mret_req), .irq(irq), .meie(meie), .mie(mie), .mtvec(mtvec),
    .core_rd_waddr(core_rd_waddr), .core_rd_wdata(core_rd_wdata),
    .core_rd_wen(core_rd_wen), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .rd_wen(rd_wen), .rb_sel(rb_sel), .rb_raddr(rb_raddr), .rb_rdata(rb_rdata),
    .trap(trap), .tret(tret), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .core_stall(core_stall)
  );

  // Regfile stand-in: write port plus one-cycle-latency rb read.
  always @(posedge clock) begin
    if (rd_wen) mem[rd_waddr] <= rd_wdata;
    rb_rdata <= mem[rb_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc_no, obs, expv);
    end
  endtask

  task automatic push(input logic wen, input logic [5:0] wa, input logic [31:0] wd,
                      input logic rbs, input logic tr, input logic rt,
                      input logic red, input logic [31:0] tgt, input logic stall);
    exp_t e;
    e.rd_wen = wen; e.rd_waddr = wa; e.rd_wdata = wd;
    e.rb_sel = rbs; e.rb_raddr = rbs ? MEPC_A : 6'h0;
    e.trap = tr; e.tret = rt; e.pc_redirect = red; e.pc_target = tgt;
    e.core_stall = stall;
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    push(core_rd_wen, core_rd_waddr, core_rd_wdata, 0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tgt);
    push(1, MEPC_A,   pc,    0, 1, 0, 0, 32'h0, 1);
    push(1, MCAUSE_A, cause, 0, 0, 0, 0, 32'h0, 1);
    push(0, 6'h0, 32'h0, 0, 0, 0, 1, tgt, 1);
  endtask

  task automatic cyc();
    exp_t e;
    #3;
    checks++;
    assert (exp_q.size() > 0) else begin
      failures++;
      $error("FAIL queue_empty cyc=%0d observed=%0d expected=%0d", cyc_no, 0, 1);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_wen",      32'(rd_wen),      32'(e.rd_wen));
      chk("rd_waddr",    32'(rd_waddr),    32'(e.rd_waddr));
      chk("rd_wdata",    rd_wdata,         e.rd_wdata);
      chk("rb_sel",      32'(rb_sel),      32'(e.rb_sel));
      chk("rb_raddr",    32'(rb_raddr),    32'(e.rb_raddr));
      chk("trap",        32'(trap),        32'(e.trap));
      chk("tret",        32'(tret),        32'(e.tret));
      chk("pc_redirect", 32'(pc_redirect), 32'(e.pc_redirect));
      chk("pc_target",   pc_target,        e.pc_target);
      chk("core_stall",  32'(core_stall),  32'(e.core_stall));
    end
    @(posedge clock);
    #1;
    cyc_no++;
  endtask

  task automatic quiet();
    exc_req = 0; mret_req = 0; irq = 0; core_rd_wen = 0;
    core_rd_waddr = 6'h0; core_rd_wdata = 32'h0;
    exc_cause = 4'h0; exc_pc = 32'hFFFF_FFF0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 0; instr_boundary = 1; meie = 1; mie = 1; mtvec = 32'h0000_0200;
    quiet();
    #1;

    // Reset holds every output low, even with a core write pending.
    core_rd_wen = 1; core_rd_waddr = 6'h05; core_rd_wdata = 32'hDEAD_BEEF;
    push(0, 6'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0); cyc();
    push(0, 6'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0); cyc();
    reset = 1;
    push_idle(); cyc();

    // Exception
    quiet();
    exc_req = 1; exc_cause = 4'd2; exc_pc = 32'h0000_0100;
    push_idle(); cyc();
    quiet();
    push_trap(32'h0000_0100, 32'h0000_0002, 32'h0000_0200);
    cyc(); cyc(); cyc();
    push_idle(); cyc();

    // Interrupt
    irq = 1; exc_pc = 32'h0000_0040;
    push_idle(); cyc();
    quiet();
    push_trap(32'h0000_0040, 32'h8000_000B, 32'h0000_0200);
    cyc(); cyc(); cyc();
    push_idle(); cyc();

    // Interrupt masked by mie
    mie = 0; irq = 1; exc_pc = 32'h0000_0040;
    push_idle(); cyc();
    push_idle(); cyc();
    push_idle(); cyc();
    quiet(); mie = 1;

    // Priority: exception beats interrupt and mret
    exc_req = 1; exc_cause = 4'd5; exc_pc = 32'h0000_0300; irq = 1; mret_req = 1;
    push_idle(); cyc();
    quiet();
    push_trap(32'h0000_0300, 32'h0000_0005, 32'h0000_0200);
    cyc(); cyc(); cyc();
    push_idle(); cyc();

    // MRET: preload MEPC through the pass-through, then return
    core_rd_wen = 1; core_rd_waddr = MEPC_A; core_rd_wdata = 32'h0000_0123;
    push_idle(); cyc();
    quiet();
    mret_req = 1;
    push_idle(); cyc();
    quiet();
    push(0, 6'h0, 32'h0, 1, 0, 0, 0, 32'h0, 1); cyc();
    push(0, 6'h0, 32'h0, 1, 0, 1, 1, 32'h0000_0120, 1); cyc();
    push_idle(); cyc();

    // Reset during WR_MCAUSE abandons the sequence
    exc_req = 1; exc_cause = 4'd7; exc_pc = 32'h0000_0500;
    push_idle(); cyc();
    quiet();
    push(1, MEPC_A, 32'h0000_0500, 0, 1, 0, 0, 32'h0, 1); cyc();
    reset = 0;
    push(0, 6'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0); cyc();
    reset = 1;
    core_rd_wen = 1; core_rd_waddr = 6'h03; core_rd_wdata = 32'h0000_0055;
    push_idle(); cyc();
    quiet();
    push_idle(); cyc();

    // Vector mode in mtvec
    mtvec = 32'h0000_1001;
    irq = 1; exc_pc = 32'h0000_0080;
    push_idle(); cyc();
    quiet();
`ifdef FWRISC_TRAP_VECTORED_EN
    push_trap(32'h0000_0080, 32'h8000_000B, 32'h0000_102C);
`else
    push_trap(32'h0000_0080, 32'h8000_000B, 32'h0000_1000);
`endif
    cyc(); cyc(); cyc();
    push_idle(); cyc();
    exc_req = 1; exc_cause = 4'd3; exc_pc = 32'h0000_0090;
    push_idle(); cyc();
    quiet();
    push_trap(32'h0000_0090, 32'h0000_0003, 32'h0000_1000);
    cyc(); cyc(); cyc();
    push_idle(); cyc();

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_leftover observed=%0d expected=%0d", exp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
